// File: rtl/alu_pattern_engine.sv
// alu_pattern_engine: pattern applier and response checker for the 2-bit alu core.
// Accepts one pattern at a time and fills its X bits. It drives the filled PI vector
// into the alu and waits SETTLE_CYC cycles. It then strobes zout against the captured
// expectation under the captured mask.
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   pat_valid/pat_ready       pattern handshake
//   pat_pi, pat_pi_x          5-bit PI vector ([4:3]=ain, [2:1]=bin, [0]=sel) and X flags
//   pat_xpct, pat_mask        expected zout and per-bit compare mask
//   pat_last                  final pattern of the set
//   ain, bin, sel             registered drive into the alu
//   zout                      alu response
//   fail_pulse, fail_bits     miscompare pulse and masked difference of the last strobe
//   pat_cnt, fail_cnt         saturating pattern and failure counters
//   toggle_cnt                saturating sum of PI Hamming distances between applied vectors
//   done                      set by the pat_last strobe, cleared by the next accept
module alu_pattern_engine #(
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned FILL_MODE  = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pat_valid,
   output logic             pat_ready,
   input  logic [4:0]       pat_pi,
   input  logic [4:0]       pat_pi_x,
   input  logic [1:0]       pat_xpct,
   input  logic [1:0]       pat_mask,
   input  logic             pat_last,
   output logic [1:0]       ain,
   output logic [1:0]       bin,
   output logic             sel,
   input  logic [1:0]       zout,
   output logic             fail_pulse,
   output logic [1:0]       fail_bits,
   output logic [CNT_W-1:0] pat_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] toggle_cnt,
   output logic             done
);

   localparam int unsigned PI_W = 5;
   localparam int unsigned Z_W  = 2;
   localparam int unsigned SC_W = 8;
   localparam int unsigned TG_W = 3;
   localparam int unsigned SUM_W = CNT_W + TG_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, APPLY, STROBE} state_t;

   state_t           state, state_d;
   logic [SC_W-1:0]  settle, settle_d;
   logic             accept, strobe, ready_d;
   logic [PI_W-1:0]  pi_q, filled;
   logic [Z_W-1:0]   xpct_q, mask_q, miss;
   logic             last_q;
   logic [TG_W-1:0]  tog_inc;

   // Saturating add; the sum is wide enough for any increment up to 7.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [TG_W-1:0] inc);
      logic [SUM_W-1:0] s;
      s = SUM_W'(a) + SUM_W'(inc);
      return (s > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(s);
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         settle <= '0;
      end else begin
         state  <= state_d;
         settle <= settle_d;
      end
   end

   // Next state and handshake decode
   always_comb begin
      state_d  = state;
      settle_d = settle;
      accept   = 1'b0;
      strobe   = 1'b0;
      case (state)
         IDLE: begin
            if (pat_valid && pat_ready) begin
               accept   = 1'b1;
               state_d  = APPLY;
               settle_d = SC_W'(SETTLE_CYC - 1);
            end
         end
         APPLY: begin
            if (settle == '0) state_d  = STROBE;
            else              settle_d = settle - SC_W'(1);
         end
         STROBE: begin
            strobe  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   // X fill against the currently applied vector
   always_comb begin
      filled = pat_pi;
      for (int i = 0; i < int'(PI_W); i++) begin
         if (pat_pi_x[i]) begin
            if (FILL_MODE == 0)      filled[i] = 1'b0;
            else if (FILL_MODE == 1) filled[i] = 1'b1;
            else                     filled[i] = pi_q[i];
         end
      end
   end

   // Hamming distance between the new and previously applied vector
   always_comb begin
      tog_inc = '0;
      for (int i = 0; i < int'(PI_W); i++) begin
         tog_inc = tog_inc + TG_W'(filled[i] ^ pi_q[i]);
      end
   end

   assign miss = (zout ^ xpct_q) & mask_q;

   // Pattern capture, strobe compare and statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         pat_ready  <= 1'b0;
         pi_q       <= '0;
         xpct_q     <= '0;
         mask_q     <= '0;
         last_q     <= 1'b0;
         fail_pulse <= 1'b0;
         fail_bits  <= '0;
         pat_cnt    <= '0;
         fail_cnt   <= '0;
         toggle_cnt <= '0;
         done       <= 1'b0;
      end else begin
         pat_ready  <= ready_d;
         fail_pulse <= 1'b0;
         if (accept) begin
            pi_q       <= filled;
            xpct_q     <= pat_xpct;
            mask_q     <= pat_mask;
            last_q     <= pat_last;
            toggle_cnt <= sat_add(toggle_cnt, tog_inc);
            done       <= 1'b0;
         end
         if (strobe) begin
            pat_cnt   <= sat_add(pat_cnt, TG_W'(1));
            fail_bits <= miss;
            if (|miss) begin
               fail_cnt   <= sat_add(fail_cnt, TG_W'(1));
               fail_pulse <= 1'b1;
            end
            if (last_q) done <= 1'b1;
         end
      end
   end

   // The applied vector is held between patterns
   assign ain = pi_q[4:3];
   assign bin = pi_q[2:1];
   assign sel = pi_q[0];

endmodule

// File: tb/tb_alu_pattern_engine.sv
// Bench for alu_pattern_engine: three instances share one stimulus stream
// (adjacent-fill/16-bit, one-fill/2-bit, zero-fill/16-bit counters) each with a golden alu.
module tb_alu_pattern_engine;

   localparam int unsigned SETTLE = 2;
   localparam int N = 3;

   typedef struct {
      int               cyc;
      logic [2:0][4:0]  pi;
      logic [2:0][1:0]  fb;
      logic [2:0]       fl;
      logic [2:0][31:0] pat;
      logic [2:0][31:0] fail;
      logic [2:0][31:0] tog;
      logic             last;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pat_valid = 1'b0;
   logic [4:0] pat_pi = '0, pat_pi_x = '0;
   logic [1:0] pat_xpct = '0, pat_mask = '0, zflip = '0;
   logic pat_last = 1'b0;

   logic       ready_w [N];
   logic [1:0] ain_w [N], bin_w [N], fb_w [N];
   logic       sel_w [N], fp_w [N], done_w [N];
   logic [15:0] pc_w [N], fc_w [N], tc_w [N];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   sb_t sbq[$];

   int fm [N] = '{2, 1, 0};
   int cmax [N] = '{65535, 3, 65535};
   logic [4:0] mprev [N];
   int mtog [N], mpat [N], mfail [N];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [1:0] alu_f(input logic [1:0] a, input logic [1:0] b, input logic s);
      return s ? (a & b) : ~(a | b);
   endfunction

   function automatic logic [4:0] fill(input int mode, input logic [4:0] pi, input logic [4:0] x,
                                       input logic [4:0] prev);
      logic [4:0] r;
      for (int i = 0; i < 5; i++) begin
         if (!x[i])          r[i] = pi[i];
         else if (mode == 0) r[i] = 1'b0;
         else if (mode == 1) r[i] = 1'b1;
         else                r[i] = prev[i];
      end
      return r;
   endfunction

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int unsigned FM = (g == 0) ? 2 : ((g == 1) ? 1 : 0);
      localparam int unsigned CW = (g == 1) ? 2 : 16;
      logic rdy, s, fp, dn;
      logic [1:0] a, b, fbits, z;
      logic [CW-1:0] pc, fc, tc;
      assign z = alu_f(a, b, s) ^ zflip;
      alu_pattern_engine #(.SETTLE_CYC(SETTLE), .FILL_MODE(FM), .CNT_W(CW)) u_dut (
         .clk(clk), .rst(rst), .pat_valid(pat_valid), .pat_ready(rdy),
         .pat_pi(pat_pi), .pat_pi_x(pat_pi_x), .pat_xpct(pat_xpct), .pat_mask(pat_mask),
         .pat_last(pat_last), .ain(a), .bin(b), .sel(s), .zout(z),
         .fail_pulse(fp), .fail_bits(fbits), .pat_cnt(pc), .fail_cnt(fc),
         .toggle_cnt(tc), .done(dn));
      assign ready_w[g] = rdy;
      assign ain_w[g]   = a;
      assign bin_w[g]   = b;
      assign sel_w[g]   = s;
      assign fp_w[g]    = fp;
      assign fb_w[g]    = fbits;
      assign done_w[g]  = dn;
      assign pc_w[g]    = 16'(pc);
      assign fc_w[g]    = 16'(fc);
      assign tc_w[g]    = 16'(tc);
   end

   // Scoreboard: pop the entry whose strobe edge just passed and compare all instances
   bit   pulse_chk = 1'b0;
   sb_t  me;
   always @(negedge clk) begin
      if (pulse_chk) begin
         for (int g = 0; g < N; g++) check($sformatf("pulse_clear%0d", g), 32'(fp_w[g]), 32'(0));
         pulse_chk = 1'b0;
      end
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
         me = sbq.pop_front();
         for (int g = 0; g < N; g++) begin
            check($sformatf("pi%0d", g), 32'({ain_w[g], bin_w[g], sel_w[g]}), 32'(me.pi[g]));
            check($sformatf("fail_bits%0d", g), 32'(fb_w[g]), 32'(me.fb[g]));
            check($sformatf("fail_pulse%0d", g), 32'(fp_w[g]), 32'(me.fl[g]));
            check($sformatf("pat_cnt%0d", g), 32'(pc_w[g]), me.pat[g]);
            check($sformatf("fail_cnt%0d", g), 32'(fc_w[g]), me.fail[g]);
            check($sformatf("toggle_cnt%0d", g), 32'(tc_w[g]), me.tog[g]);
            check($sformatf("done%0d", g), 32'(done_w[g]), 32'(me.last));
         end
         pulse_chk = 1'b1;
      end
   end

   task automatic model_clear();
      for (int g = 0; g < N; g++) begin
         mprev[g] = '0; mtog[g] = 0; mpat[g] = 0; mfail[g] = 0;
      end
      sbq.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      pat_valid = 1'b0;
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
         check($sformatf("rst_ready%0d", g), 32'(ready_w[g]), 32'(0));
         check($sformatf("rst_pins%0d", g),
               32'({ain_w[g], bin_w[g], sel_w[g], fp_w[g], fb_w[g], done_w[g]}), 32'(0));
         check($sformatf("rst_cnts%0d", g), {pc_w[g], fc_w[g]}, 32'(0));
         check($sformatf("rst_tog%0d", g), 32'(tc_w[g]), 32'(0));
      end
      rst = 1'b0;
      model_clear();
   endtask

   // Offer one pattern (called at a negedge); returns at the negedge after the accept edge
   task automatic drive(input logic [4:0] pi, input logic [4:0] x, input logic [1:0] xp,
                        input logic [1:0] mk, input logic lst, input bit keep, output int ac);
      sb_t e;
      int n, t;
      logic [4:0] f;
      logic [1:0] z, fbv;
      pat_pi = pi; pat_pi_x = x; pat_xpct = xp; pat_mask = mk; pat_last = lst;
      pat_valid = 1'b1;
      n = 0;
      while (!ready_w[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready_w[0]) begin
         check("accept_timeout", 32'(0), 32'(1));
         pat_valid = 1'b0;
         ac = -1;
         return;
      end
      ac = cyc + 1;
      e.cyc = ac + int'(SETTLE) + 1;
      e.last = lst;
      for (int g = 0; g < N; g++) begin
         f = fill(fm[g], pi, x, mprev[g]);
         t = $countones(f ^ mprev[g]);
         mtog[g] = sat(mtog[g] + t, cmax[g]);
         mprev[g] = f;
         z = alu_f(f[4:3], f[2:1], f[0]) ^ zflip;
         fbv = (z ^ xp) & mk;
         mpat[g] = sat(mpat[g] + 1, cmax[g]);
         if (|fbv) mfail[g] = sat(mfail[g] + 1, cmax[g]);
         e.pi[g] = f; e.fb[g] = fbv; e.fl[g] = |fbv;
         e.pat[g] = 32'(mpat[g]); e.fail[g] = 32'(mfail[g]); e.tog[g] = 32'(mtog[g]);
      end
      sbq.push_back(e);
      @(negedge clk);
      if (!keep) pat_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() > 0) check("drain_timeout", 32'(sbq.size()), 32'(0));
   endtask

   int ac;
   int acs [9];
   logic [4:0] p;

   initial begin
      model_clear();
      do_reset();

      // Basic pass with strobe timing
      zflip = 2'b00;
      drive(5'b11101, 5'b0, 2'b10, 2'b11, 1'b0, 1'b0, ac);
      while (cyc < ac + int'(SETTLE)) @(negedge clk);
      check("pre_strobe_pat_cnt", 32'(pc_w[2]), 32'(0));
      drain();
      check("t1_pat_cnt", 32'(pc_w[2]), 32'(1));
      check("t1_fail_cnt", 32'(fc_w[2]), 32'(0));

      // zout[0] corrupted: masked off passes, unmasked fails
      zflip = 2'b01;
      drive(5'b11100, 5'b0, 2'b00, 2'b10, 1'b0, 1'b0, ac);
      drive(5'b11100, 5'b0, 2'b00, 2'b11, 1'b0, 1'b0, ac);
      drain();
      check("t2_fail_cnt", 32'(fc_w[2]), 32'(1));
      check("t2_fail_bits", 32'(fb_w[2]), 32'(2'b01));
      zflip = 2'b00;

      // Fill policies from a fresh prev vector
      do_reset();
      drive(5'b01101, 5'b0, 2'b00, 2'b00, 1'b0, 1'b0, ac);
      drive(5'b00000, 5'b11111, 2'b00, 2'b00, 1'b0, 1'b0, ac);
      drain();
      check("t3_adj_pi", 32'({ain_w[0], bin_w[0], sel_w[0]}), 32'(5'b01101));
      check("t3_adj_tog", 32'(tc_w[0]), 32'(3));
      check("t3_zero_pi", 32'({ain_w[2], bin_w[2], sel_w[2]}), 32'(5'b00000));
      check("t3_zero_tog", 32'(tc_w[2]), 32'(6));
      check("t3_one_tog_sat", 32'(tc_w[1]), 32'(3));

      // Streaming with pat_valid held high
      do_reset();
      for (int k = 0; k < 9; k++) begin
         p = 5'($urandom);
         drive(p, 5'($urandom), 2'($urandom), 2'($urandom), (k == 8), 1'b1, ac);
         acs[k] = ac;
      end
      pat_valid = 1'b0;
      for (int k = 1; k < 9; k++) check("stream_gap", 32'(acs[k] - acs[k-1]), 32'(SETTLE + 2));
      drain();
      check("t4_done", 32'(done_w[0]), 32'(1));
      check("t4_pat_cnt", 32'(pc_w[0]), 32'(9));

      // Accept clears done; reset during APPLY aborts the pattern
      drive(5'b10110, 5'b0, 2'b00, 2'b11, 1'b0, 1'b0, ac);
      check("t5_done_clr", 32'(done_w[0]), 32'(0));
      do_reset();
      drive(5'b11101, 5'b0, 2'b10, 2'b11, 1'b0, 1'b0, ac);
      drain();
      check("t5_pat_cnt", 32'(pc_w[0]), 32'(1));

      // Saturating fail counter
      do_reset();
      zflip = 2'b11;
      for (int k = 0; k < 5; k++) begin
         p = 5'($urandom);
         drive(p, 5'b0, alu_f(p[4:3], p[2:1], p[0]), 2'b11, 1'b0, 1'b0, ac);
      end
      drain();
      check("t6_fail_sat", 32'(fc_w[1]), 32'(3));
      check("t6_fail_wide", 32'(fc_w[2]), 32'(5));
      zflip = 2'b00;

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
